// File: rtl/backend_dispatch_sequencer_pkg.sv
// Shared dispatch types for the backend dispatch sequencer.
// Default lane, channel and EU-index widths also live here.
package pkg_dtypes;

   localparam int DEF_NUM_PARALLEL_INSTR_DISPATCHES = 2;
   localparam int DEF_LOG2_NUM_EXEC_UNITS = 2;
   localparam int DEF_LOG2_NUM_ICON_CHANNELS = 2;
   localparam int DEF_NUM_ICON_CHANNELS = 2 ** DEF_LOG2_NUM_ICON_CHANNELS;

   typedef struct packed {
      logic [7:0] tag;
      logic [5:0] opcode;
      logic [4:0] dst;
      logic [4:0] src;
   } type_iqueue_entry;

   typedef struct packed {
      logic [7:0]  tag;
      logic [3:0]  op;
      logic [11:0] payload;
   } type_icon_instr;

   typedef struct packed {
      type_iqueue_entry [DEF_NUM_PARALLEL_INSTR_DISPATCHES-1:0] instr;
      logic [DEF_NUM_PARALLEL_INSTR_DISPATCHES-1:0] instr_valid;
      logic [DEF_NUM_PARALLEL_INSTR_DISPATCHES-1:0]
            [DEF_LOG2_NUM_EXEC_UNITS-1:0] euidx;
      type_icon_instr [DEF_NUM_ICON_CHANNELS-1:0] icon;
      logic [DEF_NUM_ICON_CHANNELS-1:0] icon_valid;
   } type_dispatch_group;

   // A part is finished once sent, handshaking now, or never valid.
   function automatic logic part_done(
      input logic valid,
      input logic sent,
      input logic hs
   );
      return sent | hs | ~valid;
   endfunction

endpackage

// File: rtl/backend_dispatch_sequencer_fifo.sv
// Circular FIFO of whole dispatch groups with synchronous flush.
// Head entry is presented combinationally from the read pointer.
module dispatch_group_fifo
   import pkg_dtypes::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = type_dispatch_group
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];

   // Pointers are power-of-two wide, so increment wraps modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/backend_dispatch_sequencer.sv
// Releases buffered dispatch groups onto the IQueue and icon buses,
// retiring a group once its IQueue part and every icon channel finish.
module backend_dispatch_sequencer
   import pkg_dtypes::*;
#(
   parameter int NUM_PARALLEL_INSTR_DISPATCHES =
      DEF_NUM_PARALLEL_INSTR_DISPATCHES,
   parameter int LOG2_NUM_EXEC_UNITS = DEF_LOG2_NUM_EXEC_UNITS,
   parameter int NUM_ICON_CHANNELS   = DEF_NUM_ICON_CHANNELS,
   parameter int DEPTH               = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic flush_i,
   input  logic grp_valid_i,
   output logic grp_ready_o,
   input  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                grp_instr_i,
   input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                grp_instr_valid_i,
   input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                [LOG2_NUM_EXEC_UNITS-1:0] grp_euidx_i,
   input  type_icon_instr [NUM_ICON_CHANNELS-1:0] grp_icon_i,
   input  logic [NUM_ICON_CHANNELS-1:0] grp_icon_valid_i,
   output type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                instr_dispatch_o,
   output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                instr_dispatch_valid_o,
   output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]
                [LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o,
   input  logic instr_dispatch_ready_i,
   output type_icon_instr [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_o,
   output logic [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_valid_o,
   input  logic [NUM_ICON_CHANNELS-1:0] icon_instr_dispatch_ready_i,
   output logic [$clog2(DEPTH):0] occupancy_o
);

   localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
   localparam int C  = NUM_ICON_CHANNELS;
   localparam int EW = LOG2_NUM_EXEC_UNITS;

   typedef struct packed {
      type_iqueue_entry [N-1:0] instr;
      logic [N-1:0]             instr_valid;
      logic [N-1:0][EW-1:0]     euidx;
      type_icon_instr [C-1:0]   icon;
      logic [C-1:0]             icon_valid;
   } grp_t;

   grp_t         push_grp;
   grp_t         head;
   logic         full;
   logic         empty;
   logic         nonempty;
   logic         push;
   logic         pop;
   logic         iq_sent;
   logic [C-1:0] icon_sent;
   logic         iq_hs;
   logic         iq_done;
   logic [C-1:0] icon_hs;
   logic [C-1:0] icon_done;

   assign push_grp.instr       = grp_instr_i;
   assign push_grp.instr_valid = grp_instr_valid_i;
   assign push_grp.euidx       = grp_euidx_i;
   assign push_grp.icon        = grp_icon_i;
   assign push_grp.icon_valid  = grp_icon_valid_i;

   assign grp_ready_o = ~full;
   assign push        = grp_valid_i & ~full & ~flush_i;
   assign nonempty    = ~empty;

   dispatch_group_fifo #(
      .DEPTH (DEPTH),
      .T     (grp_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_i),
      .push      (push),
      .push_data (push_grp),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (occupancy_o)
   );

   // Data is zeroed while empty so stale RAM never shows on the bus.
   assign instr_dispatch_o = nonempty ? head.instr : '0;
   assign dispatched_instr_alloc_euidx_o = nonempty ? head.euidx : '0;
   assign icon_instr_dispatch_o = nonempty ? head.icon : '0;

   assign instr_dispatch_valid_o =
      head.instr_valid & {N{nonempty & ~iq_sent & ~flush_i}};
   assign icon_instr_dispatch_valid_o =
      head.icon_valid & ~icon_sent & {C{nonempty & ~flush_i}};

   assign iq_hs   = (|instr_dispatch_valid_o) & instr_dispatch_ready_i;
   assign icon_hs = icon_instr_dispatch_valid_o & icon_instr_dispatch_ready_i;

   always_comb begin
      iq_done   = part_done(|head.instr_valid, iq_sent, iq_hs);
      icon_done = '0;
      for (int c = 0; c < C; c++) begin
         icon_done[c] = part_done(head.icon_valid[c], icon_sent[c],
                                  icon_hs[c]);
      end
   end

   assign pop = nonempty & ~flush_i & iq_done & (&icon_done);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iq_sent   <= 1'b0;
         icon_sent <= '0;
      end else if (flush_i || pop) begin
         iq_sent   <= 1'b0;
         icon_sent <= '0;
      end else begin
         iq_sent   <= iq_sent | iq_hs;
         icon_sent <= icon_sent | icon_hs;
      end
   end

   a_occ_bound: assert property (@(posedge clk) disable iff (reset)
      occupancy_o <= ($clog2(DEPTH)+1)'(DEPTH));

   a_iq_stable: assert property (@(posedge clk) disable iff (reset)
      ((|instr_dispatch_valid_o) && !instr_dispatch_ready_i && !flush_i)
      |=> $stable(instr_dispatch_o));

endmodule

// File: tb/tb_backend_dispatch_sequencer.sv
// Random + directed bench for backend_dispatch_sequencer with a
// group-level reference model and negedge scoreboard monitor.
module tb_backend_dispatch_sequencer;
   import pkg_dtypes::*;

   localparam int N     = 2;
   localparam int EW    = 2;
   localparam int C     = 4;
   localparam int DEPTH = 4;
   localparam int OW    = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush_i = 1'b0;
   logic grp_valid_i = 1'b0;
   logic grp_ready_o;
   type_iqueue_entry [N-1:0] grp_instr_i = '0;
   logic [N-1:0] grp_instr_valid_i = '0;
   logic [N-1:0][EW-1:0] grp_euidx_i = '0;
   type_icon_instr [C-1:0] grp_icon_i = '0;
   logic [C-1:0] grp_icon_valid_i = '0;
   type_iqueue_entry [N-1:0] instr_dispatch_o;
   logic [N-1:0] instr_dispatch_valid_o;
   logic [N-1:0][EW-1:0] dispatched_instr_alloc_euidx_o;
   logic instr_dispatch_ready_i = 1'b0;
   type_icon_instr [C-1:0] icon_instr_dispatch_o;
   logic [C-1:0] icon_instr_dispatch_valid_o;
   logic [C-1:0] icon_instr_dispatch_ready_i = '0;
   logic [OW-1:0] occupancy_o;

   always #5 clk = ~clk;

   backend_dispatch_sequencer #(
      .NUM_PARALLEL_INSTR_DISPATCHES (N),
      .LOG2_NUM_EXEC_UNITS           (EW),
      .NUM_ICON_CHANNELS             (C),
      .DEPTH                         (DEPTH)
   ) dut (
      .clk                            (clk),
      .reset                          (reset),
      .flush_i                        (flush_i),
      .grp_valid_i                    (grp_valid_i),
      .grp_ready_o                    (grp_ready_o),
      .grp_instr_i                    (grp_instr_i),
      .grp_instr_valid_i              (grp_instr_valid_i),
      .grp_euidx_i                    (grp_euidx_i),
      .grp_icon_i                     (grp_icon_i),
      .grp_icon_valid_i               (grp_icon_valid_i),
      .instr_dispatch_o               (instr_dispatch_o),
      .instr_dispatch_valid_o         (instr_dispatch_valid_o),
      .dispatched_instr_alloc_euidx_o (dispatched_instr_alloc_euidx_o),
      .instr_dispatch_ready_i         (instr_dispatch_ready_i),
      .icon_instr_dispatch_o          (icon_instr_dispatch_o),
      .icon_instr_dispatch_valid_o    (icon_instr_dispatch_valid_o),
      .icon_instr_dispatch_ready_i    (icon_instr_dispatch_ready_i),
      .occupancy_o                    (occupancy_o)
   );

   // Expected group plus which of its parts have been seen on the bus.
   typedef struct {
      type_iqueue_entry [N-1:0] instr;
      logic [N-1:0]             iv;
      logic [N-1:0][EW-1:0]     eu;
      type_icon_instr [C-1:0]   icon;
      logic [C-1:0]             cv;
      bit                       iq_seen;
      logic [C-1:0]             seen;
   } mgrp_t;

   mgrp_t model[$];
   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   mgrp_t        h;
   mgrp_t        ng;
   int           sz;
   logic [N-1:0] e_iv;
   logic [C-1:0] e_cv;

   always @(negedge clk) begin
      if (reset) begin
         model.delete();
         check("rst_occ", 128'(occupancy_o), 128'(0));
         check("rst_ready", 128'(grp_ready_o), 128'(1));
         check("rst_iqv", 128'(instr_dispatch_valid_o), 128'(0));
         check("rst_iconv", 128'(icon_instr_dispatch_valid_o), 128'(0));
         check("rst_data", 128'(instr_dispatch_o), 128'(0));
      end else begin
         sz = model.size();
         check("occupancy", 128'(occupancy_o), 128'(sz));
         check("grp_ready", 128'(grp_ready_o), 128'(sz != DEPTH));
         e_iv = '0;
         e_cv = '0;
         if (sz > 0) begin
            h = model[0];
            if (!flush_i && !h.iq_seen) e_iv = h.iv;
            if (!flush_i) e_cv = h.cv & ~h.seen;
            check("iq_data", 128'(instr_dispatch_o), 128'(h.instr));
            check("eu_data", 128'(dispatched_instr_alloc_euidx_o),
                  128'(h.eu));
            check("icon_data", 128'(icon_instr_dispatch_o), 128'(h.icon));
         end else begin
            check("idle_data", 128'(instr_dispatch_o), 128'(0));
            check("idle_icon", 128'(icon_instr_dispatch_o), 128'(0));
         end
         check("iq_valid", 128'(instr_dispatch_valid_o), 128'(e_iv));
         check("icon_valid", 128'(icon_instr_dispatch_valid_o),
               128'(e_cv));
         if (flush_i) begin
            model.delete();
         end else begin
            if (sz > 0) begin
               if ((|e_iv) && instr_dispatch_ready_i) h.iq_seen = 1'b1;
               h.seen = h.seen | (e_cv & icon_instr_dispatch_ready_i);
               if ((h.iv == '0 || h.iq_seen) && ((h.cv & ~h.seen) == '0))
                  void'(model.pop_front());
               else
                  model[0] = h;
            end
            if (grp_valid_i && sz < DEPTH) begin
               ng.instr   = grp_instr_i;
               ng.iv      = grp_instr_valid_i;
               ng.eu      = grp_euidx_i;
               ng.icon    = grp_icon_i;
               ng.cv      = grp_icon_valid_i;
               ng.iq_seen = 1'b0;
               ng.seen    = '0;
               model.push_back(ng);
            end
         end
      end
   end

   task automatic set_group(input int tag, input bit empty_grp);
      logic [31:0] r;
      for (int l = 0; l < N; l++) begin
         r = $urandom;
         grp_instr_i[l] = r[23:0];
         grp_instr_i[l].tag = 8'(tag);
      end
      for (int c = 0; c < C; c++) begin
         r = $urandom;
         grp_icon_i[c] = r[23:0];
         grp_icon_i[c].tag = 8'(tag);
      end
      r = $urandom;
      grp_euidx_i = r[N*EW-1:0];
      grp_instr_valid_i = empty_grp ? '0 : N'($urandom);
      grp_icon_valid_i = empty_grp ? '0 : C'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_phase(input int cycles, input int p_rdy,
                             input int p_flush, inout int tag);
      for (int i = 0; i < cycles; i++) begin
         grp_valid_i = ($urandom_range(0, 9) < 7);
         set_group(tag, $urandom_range(0, 9) == 0);
         tag++;
         instr_dispatch_ready_i = ($urandom_range(0, 99) < p_rdy);
         for (int c = 0; c < C; c++)
            icon_instr_dispatch_ready_i[c] = ($urandom_range(0, 99) < p_rdy);
         flush_i = ($urandom_range(0, 99) < p_flush);
         step();
      end
      flush_i = 1'b0;
      grp_valid_i = 1'b0;
   endtask

   int tag = 0;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // single group, all readies high
      set_group(tag++, 0);
      grp_instr_valid_i = 2'b11;
      grp_icon_valid_i = 4'b0101;
      grp_valid_i = 1'b1;
      instr_dispatch_ready_i = 1'b1;
      icon_instr_dispatch_ready_i = '1;
      step();
      grp_valid_i = 1'b0;
      repeat (3) step();

      // partial icon accept: ch2 held off for three cycles
      set_group(tag++, 0);
      grp_instr_valid_i = 2'b11;
      grp_icon_valid_i = 4'b0101;
      grp_valid_i = 1'b1;
      icon_instr_dispatch_ready_i = 4'b1011;
      step();
      grp_valid_i = 1'b0;
      repeat (3) step();
      icon_instr_dispatch_ready_i = '1;
      repeat (2) step();

      // empty group sandwiched between two normal groups
      for (int i = 0; i < 3; i++) begin
         set_group(tag++, i == 1);
         if (i != 1) grp_instr_valid_i = 2'b01;
         grp_valid_i = 1'b1;
         step();
      end
      grp_valid_i = 1'b0;
      repeat (3) step();

      // fill to full with everything blocked, then release one
      instr_dispatch_ready_i = 1'b0;
      icon_instr_dispatch_ready_i = '0;
      for (int i = 0; i < 6; i++) begin
         set_group(tag++, 0);
         grp_instr_valid_i = 2'b01;
         grp_icon_valid_i = 4'b0010;
         grp_valid_i = 1'b1;
         step();
      end
      grp_valid_i = 1'b0;
      instr_dispatch_ready_i = 1'b1;
      step();
      instr_dispatch_ready_i = 1'b0;
      icon_instr_dispatch_ready_i = 4'b0010;
      step();
      icon_instr_dispatch_ready_i = '0;
      repeat (2) step();

      // flush with ch1 already sent on the head group
      grp_valid_i = 1'b1;
      set_group(tag++, 0);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      grp_valid_i = 1'b0;
      step();

      // refill three groups, then asynchronous reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         set_group(tag++, 0);
         grp_instr_valid_i = 2'b10;
         grp_icon_valid_i = 4'b0011;
         grp_valid_i = 1'b1;
         step();
      end
      grp_valid_i = 1'b0;
      icon_instr_dispatch_ready_i = 4'b0010;
      step();
      icon_instr_dispatch_ready_i = '0;
      #2 reset = 1'b1;
      #1;
      check("async_iqv", 128'(instr_dispatch_valid_o), 128'(0));
      check("async_iconv", 128'(icon_instr_dispatch_valid_o), 128'(0));
      check("async_occ", 128'(occupancy_o), 128'(0));
      check("async_ready", 128'(grp_ready_o), 128'(1));
      step();
      reset = 1'b0;
      step();

      // streaming at full readiness, then mixed backpressure
      rand_phase(60, 100, 0, tag);
      rand_phase(300, 60, 0, tag);
      rand_phase(300, 25, 2, tag);
      rand_phase(200, 85, 1, tag);

      instr_dispatch_ready_i = 1'b1;
      icon_instr_dispatch_ready_i = '1;
      repeat (20) step();
      check("drain_occ", 128'(occupancy_o), 128'(0));
      check("drain_model", 128'(model.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
